// File: rtl/uc_tile_sequencer.sv
// Host-side sequencer for the 8-bit uC tile: generates the tile's software clock,
// serves instruction fetch and SRAM traffic, and runs host STEP/RUN commands with halt/breakpoint.
module uc_tile_sequencer #(
    parameter int unsigned PC_W  = 12,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic             halt,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    output logic             busy,
    output logic             done,
    output logic [1:0]       stop_cause,
    output logic [31:0]      cycle_cnt,
    output logic             pmem_rd,
    output logic [PC_W-1:0]  pmem_addr,
    input  logic [15:0]      pmem_rdata,
    output logic             sram_rd,
    output logic             sram_we,
    output logic [7:0]       sram_addr,
    output logic [7:0]       sram_wdata,
    input  logic [7:0]       sram_rdata,
    output logic [15:0]      tile_csr_in,
    output logic [31:0]      tile_reg_a,
    output logic [31:0]      tile_reg_b,
    input  logic [31:0]      tile_reg_c,
    input  logic [15:0]      tile_csr_out
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_RISE, S_FALL} state_t;

    localparam logic [1:0] OP_STEP    = 2'b01;
    localparam logic [1:0] OP_RUN     = 2'b10;
    localparam logic [1:0] CAUSE_CNT  = 2'b00;
    localparam logic [1:0] CAUSE_HALT = 2'b01;
    localparam logic [1:0] CAUSE_BP   = 2'b10;

    state_t            state;
    logic [CNT_W-1:0]  remaining;
    logic              run_mode;
    logic              first_cyc;
    logic              halt_pend;
    logic              uclk;
    logic              flash_ready;
    logic [7:0]        data_a;
    logic [15:0]       data_b;
    logic              unused_ok;

    assign tile_csr_in = {10'b0, uclk, flash_ready, 4'b0};
    assign tile_reg_a  = {24'b0, data_a};
    assign tile_reg_b  = {16'b0, data_b};
    assign unused_ok   = ^{tile_csr_out[15:3], tile_csr_out[1:0], tile_reg_c[31:16+PC_W]};

    // One uC cycle = FETCH, WAIT, RISE, FALL; all outputs registered on the transitions.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            stop_cause  <= CAUSE_CNT;
            cycle_cnt   <= '0;
            pmem_rd     <= 1'b0;
            pmem_addr   <= '0;
            sram_rd     <= 1'b0;
            sram_we     <= 1'b0;
            sram_addr   <= '0;
            sram_wdata  <= '0;
            remaining   <= '0;
            run_mode    <= 1'b0;
            first_cyc   <= 1'b0;
            halt_pend   <= 1'b0;
            uclk        <= 1'b0;
            flash_ready <= 1'b0;
            data_a      <= '0;
            data_b      <= '0;
        end else begin
            done    <= 1'b0;
            pmem_rd <= 1'b0;
            sram_rd <= 1'b0;
            sram_we <= 1'b0;
            if (halt && state != S_IDLE) begin
                halt_pend <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_op == OP_STEP && cmd_arg == '0) begin
                        stop_cause <= CAUSE_CNT;
                        done       <= 1'b1;
                    end else if (cmd_valid && (cmd_op == OP_STEP || cmd_op == OP_RUN)) begin
                        stop_cause <= CAUSE_CNT;
                        remaining  <= cmd_arg;
                        run_mode   <= (cmd_op == OP_RUN);
                        first_cyc  <= 1'b1;
                        state      <= S_FETCH;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        pmem_rd    <= 1'b1;
                        pmem_addr  <= tile_reg_c[16 +: PC_W];
                        sram_rd    <= 1'b1;
                        sram_addr  <= tile_reg_c[7:0];
                    end
                end
                S_FETCH: begin
                    first_cyc <= 1'b0;
                    // The first uC cycle of a command ignores the breakpoint so the host can step past it.
                    if (bp_en && pmem_addr == bp_addr && !first_cyc) begin
                        state      <= S_IDLE;
                        cmd_ready  <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        stop_cause <= CAUSE_BP;
                        halt_pend  <= 1'b0;
                        run_mode   <= 1'b0;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Capture the tile's write request before the edge changes its outputs.
                    data_b      <= pmem_rdata;
                    data_a      <= sram_rdata;
                    sram_we     <= tile_csr_out[2];
                    sram_addr   <= tile_reg_c[7:0];
                    sram_wdata  <= tile_reg_c[15:8];
                    uclk        <= 1'b1;
                    flash_ready <= 1'b1;
                    cycle_cnt   <= cycle_cnt + 32'd1;
                    state       <= S_RISE;
                end
                S_RISE: begin
                    uclk  <= 1'b0;
                    state <= S_FALL;
                end
                S_FALL: begin
                    flash_ready <= 1'b0;
                    if (halt_pend || halt || (!run_mode && remaining == CNT_W'(1))) begin
                        state      <= S_IDLE;
                        cmd_ready  <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        stop_cause <= (halt_pend || halt) ? CAUSE_HALT : CAUSE_CNT;
                        halt_pend  <= 1'b0;
                        run_mode   <= 1'b0;
                        if (!run_mode) begin
                            remaining <= remaining - CNT_W'(1);
                        end
                    end else begin
                        if (!run_mode) begin
                            remaining <= remaining - CNT_W'(1);
                        end
                        state     <= S_FETCH;
                        pmem_rd   <= 1'b1;
                        pmem_addr <= tile_reg_c[16 +: PC_W];
                        sram_rd   <= 1'b1;
                        sram_addr <= tile_reg_c[7:0];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
